m_ext_issue: RTL and testbench
==============================

// Module: m_ext_issue
// PURPOSE
//  Core-side initiator for the RV32M unit: accepts MUL*/DIV*/REM* requests from decode.
//  Computes multiplies locally.
//  Drives the divider wrapper's go/done handshake and holds its operands stable until done.
//  Returns one writeback response per request and stalls the pipeline while busy.
// PARAMETERS
//  XLEN         32  operand/result width (only 32 supported)
//  DIV_TIMEOUT  64  cycles after div_go with no div_done before abort; 8..255
// PORTS
//  clk        in   1     single clock, all flops on posedge
//  clr_n      in   1     asynchronous, active-low reset
//  req_valid  in   1     decode presents an M-ext op
//  req_ready  out  1     high only in IDLE; accept = req_valid & req_ready
//  req_funct3 in   3     RV32M funct3 (000 MUL .. 111 REMU)
//  req_rs1    in   32    operand A
//  req_rs2    in   32    operand B
//  req_rd     in   5     destination register
//  flush      in   1     kill any in-flight op, no response
//  stall      out  1     = state != IDLE
//  rsp_valid  out  1     one-cycle writeback pulse
//  rsp_data   out  32    result
//  rsp_rd     out  5     destination of result
//  rsp_err    out  1     valid with rsp_valid; 1 = divider timeout
//  div_go     out  1     one-cycle start pulse to divider
//  div_clr    out  1     one-cycle divider abort pulse
//  div_func3  out  2     funct3[1:0] to divider
//  div_rs1    out  32    held stable from div_go until div_done/abort
//  div_rs2    out  32    held stable from div_go until div_done/abort
//  div_done   in   1     divider result ready; div_rd valid this cycle
//  div_rd     in   32    divider result
// BEHAVIOUR
//  Reset (clr_n=0, async): state=IDLE.
//   All outputs 0 except req_ready=1; operand, rd and timer regs 0.
//  Accept latches funct3/rs1/rs2/rd.
//  FSM: IDLE -> MUL (funct3[2]=0) | DIV_GO (funct3[2]=1).
//  MUL: registered product via sub-module; next cycle -> WB.
//    Rules: MUL low 32 bits; MULH s*s high 32; MULHSU s*u high 32; MULHU u*u high 32.
//    Accept to rsp_valid latency = 2 cycles.
//  DIV_GO: div_go=1 for exactly one cycle, timer cleared -> DIV_WAIT.
//  DIV_WAIT: timer++ each cycle.
//    div_done=1 -> capture div_rd -> WB, rsp_err=0.
//    timer==DIV_TIMEOUT-1 and no div_done -> div_clr=1 for one cycle -> WB.
//      Timeout response: rsp_data=32'hFFFF_FFFF, rsp_err=1.
//  WB: rsp_valid=1 for one cycle -> IDLE; req_ready=1 the following cycle.
//    No back-to-back accept: at most one op in flight.
//  div_done in the same cycle as the timeout: done wins, no div_clr.
//  div_done outside DIV_WAIT: ignored.
//  flush in MUL/DIV_GO/DIV_WAIT:
//    -> IDLE next cycle; no rsp_valid.
//    div_clr=1 if div_go had been issued or is issued that cycle.
//  flush in WB: rsp_valid is suppressed.
//  flush in IDLE with req_valid: no accept.
//  div_rs1/div_rs2/div_func3 change only on accept.
// CONFIGURATION
//  DIV_SPECIAL_EN defined: RISC-V special cases resolved in DIV_GO with no div_go.
//    Resolved cases go straight to WB, latency 2.
//    rs2==0: DIV/DIVU -> 32'hFFFF_FFFF, REM/REMU -> rs1.
//    Signed rs1==32'h8000_0000 && rs2==32'hFFFF_FFFF: DIV -> 32'h8000_0000, REM -> 0.
//  DIV_SPECIAL_EN undefined: all divides go to the divider; results are whatever it returns.
// STRUCTURE
//  Package m_ext_pkg:
//    typedef enum logic[2:0] funct3_e {MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU}
//    typedef enum state_e {IDLE,MUL,DIV_GO,DIV_WAIT,WB}
//    localparam DIV_TIMEOUT_DEF=64
//  Sub-module m_ext_mul: 33x33 signed multiply.
//    Operands sign/zero-extended per funct3; output register; selects low/high word.
// TESTING
//  1. MUL 7 x 32'hFFFF_FFFD:
//     -> rsp_data=32'hFFFF_FFEB, rsp_valid exactly 2 cycles after accept, stall high 2 cycles.
//  2. MULHU 32'hFFFF_FFFF x 32'hFFFF_FFFF:
//     -> 32'hFFFF_FFFE; MULH same operands -> 0.
//  3. DIV -20/3, model divider done after 33 cycles:
//     -> single div_go pulse, div_rs1/rs2 stable throughout, rsp_data=32'hFFFF_FFFA, rsp_err=0.
//  4. DIV_SPECIAL_EN: DIVU 5/0 -> 32'hFFFF_FFFF; REM 32'h8000_0000/-1 -> 0.
//     Both in 2 cycles, div_go never asserted.
//  5. Divider never responds:
//     -> div_clr pulse at DIV_TIMEOUT, rsp_err=1, rsp_data=32'hFFFF_FFFF.
//     Then a DIVU 9/2 completes with 4.
//  6. flush in DIV_WAIT -> div_clr pulse, no rsp_valid, req_ready=1 next cycle.
//     clr_n low mid-MUL -> all outputs reset immediately.

Source files
------------

// File: rtl/m_ext_pkg.sv
// Shared types and constants for the RV32M issue block and its multiplier.
package m_ext_pkg;

  typedef enum logic [2:0] {
    F3Mul    = 3'b000,
    F3Mulh   = 3'b001,
    F3Mulhsu = 3'b010,
    F3Mulhu  = 3'b011,
    F3Div    = 3'b100,
    F3Divu   = 3'b101,
    F3Rem    = 3'b110,
    F3Remu   = 3'b111
  } funct3_e;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDivGo,
    StDivWait,
    StWb
  } state_e;

  localparam int unsigned DIV_TIMEOUT_DEF = 64;
  localparam int unsigned TIMER_W         = 8;

  // {rs1 signed, rs2 signed} for each multiply flavour.
  function automatic logic [1:0] mul_signs(funct3_e f);
    case (f)
      F3Mulh:   return 2'b11;
      F3Mulhsu: return 2'b10;
      default:  return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/m_ext_mul.sv
// Registered 33x33 signed multiplier; sign/zero extension and word select follow funct3.
module m_ext_mul
  import m_ext_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            en,
  input  funct3_e         funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] result
);

  logic [1:0]               sgn;
  logic signed [XLEN:0]     op_a;
  logic signed [XLEN:0]     op_b;
  logic signed [2*XLEN-1:0] prod_d;
  logic [2*XLEN-1:0]        prod_q;

  assign sgn  = mul_signs(funct3);
  assign op_a = $signed({sgn[1] & rs1[XLEN-1], rs1});
  assign op_b = $signed({sgn[0] & rs2[XLEN-1], rs2});

  // Low 2*XLEN bits of the 33x33 product are exact for every flavour.
  assign prod_d = (2*XLEN)'(op_a) * (2*XLEN)'(op_b);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prod_q <= '0;
    end else if (en) begin
      prod_q <= prod_d;
    end
  end

  assign result = (funct3 == F3Mul) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];

endmodule

// File: rtl/m_ext_issue.sv
// RV32M issue block: local multiply, go/done handshake to an external divider, one response per op.
// Optional DIV_SPECIAL_EN resolves divide-by-zero and signed overflow without starting the divider.
module m_ext_issue
  import m_ext_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic            stall,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic [4:0]      rsp_rd,
  output logic            rsp_err,
  output logic            div_go,
  output logic            div_clr,
  output logic [1:0]      div_func3,
  output logic [XLEN-1:0] div_rs1,
  output logic [XLEN-1:0] div_rs2,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_rd
);

  state_e               state_q, state_d;
  funct3_e              funct3_q;
  logic [XLEN-1:0]      rs1_q, rs2_q, res_q, res_d;
  logic [4:0]           rd_q;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 err_q, err_d;
  logic                 accept;
  logic                 timeout;
  logic [XLEN-1:0]      mul_result;

  assign accept  = req_valid & (state_q == StIdle) & ~flush;
  assign timeout = (timer_q == TIMER_W'(DIV_TIMEOUT - 1));

`ifdef DIV_SPECIAL_EN
  logic            spec_zero, spec_ovf;
  logic [XLEN-1:0] spec_val;
  assign spec_zero = (rs2_q == '0);
  assign spec_ovf  = ~funct3_q[0] && (rs1_q == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_q == '1);
  // Overflow quotient equals rs1 (the most negative value); remainder is zero.
  assign spec_val  = spec_zero ? (funct3_q[1] ? rs1_q : '1) : (funct3_q[1] ? '0 : rs1_q);
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= StIdle;
      funct3_q <= F3Mul;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      timer_q  <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      res_q   <= res_d;
      err_q   <= err_d;
      if (accept) begin
        funct3_q <= funct3_e'(req_funct3);
        rs1_q    <= req_rs1;
        rs2_q    <= req_rs2;
        rd_q     <= req_rd;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    res_d     = res_q;
    err_d     = err_q;
    div_go    = 1'b0;
    div_clr   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = req_funct3[2] ? StDivGo : StMul;
      end
      StMul: begin
        state_d = flush ? StIdle : StWb;
      end
      StDivGo: begin
        timer_d = '0;
        err_d   = 1'b0;
`ifdef DIV_SPECIAL_EN
        if (spec_zero || spec_ovf) begin
          res_d   = spec_val;
          state_d = flush ? StIdle : StWb;
        end else begin
          div_go  = 1'b1;
          div_clr = flush;
          state_d = flush ? StIdle : StDivWait;
        end
`else
        div_go  = 1'b1;
        div_clr = flush;
        state_d = flush ? StIdle : StDivWait;
`endif
      end
      StDivWait: begin
        timer_d = timer_q + TIMER_W'(1);
        if (flush) begin
          div_clr = 1'b1;
          state_d = StIdle;
        end else if (div_done) begin
          res_d   = div_rd;
          err_d   = 1'b0;
          state_d = StWb;
        end else if (timeout) begin
          div_clr = 1'b1;
          res_d   = '1;
          err_d   = 1'b1;
          state_d = StWb;
        end
      end
      StWb: begin
        rsp_valid = ~flush;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  m_ext_mul #(
    .XLEN (XLEN)
  ) u_mul (
    .clk    (clk),
    .clr_n  (clr_n),
    .en     (state_q == StMul),
    .funct3 (funct3_q),
    .rs1    (rs1_q),
    .rs2    (rs2_q),
    .result (mul_result)
  );

  assign req_ready = (state_q == StIdle);
  assign stall     = (state_q != StIdle);
  assign rsp_data  = rsp_valid ? (funct3_q[2] ? res_q : mul_result) : '0;
  assign rsp_rd    = rsp_valid ? rd_q : '0;
  assign rsp_err   = rsp_valid & err_q;
  assign div_func3 = funct3_q[1:0];
  assign div_rs1   = rs1_q;
  assign div_rs2   = rs2_q;

endmodule

// File: tb/tb_m_ext_issue.sv
// Self-checking bench for m_ext_issue with a behavioural divider responder and reference model.
module tb_m_ext_issue;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        stall, rsp_valid, rsp_err, div_go, div_clr;
  logic [31:0] rsp_data, div_rs1, div_rs2;
  logic [4:0]  rsp_rd;
  logic [1:0]  div_func3;
  logic        div_done = 1'b0;
  logic [31:0] div_rd = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // Divider responder configuration and state
  bit          div_never = 1'b0;
  int          div_lat   = 5;
  bit          pending   = 1'b0;
  int          cnt       = 0;
  logic [31:0] dres      = '0;

  // Results of the last do_op
  int          r_lat, r_gos, r_clrs, r_go_at, r_clr_at, r_stalls, r_unstable;
  logic [31:0] r_data;
  logic        r_err;
  logic [4:0]  r_rd;

  always #5 clk = ~clk;

  m_ext_issue #(
    .XLEN        (32),
    .DIV_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .flush      (flush),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_rd     (rsp_rd),
    .rsp_err    (rsp_err),
    .div_go     (div_go),
    .div_clr    (div_clr),
    .div_func3  (div_func3),
    .div_rs1    (div_rs1),
    .div_rs2    (div_rs2),
    .div_done   (div_done),
    .div_rd     (div_rd)
  );

  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    logic [63:0]     p;
    case (f3)
      3'd1:    p = sa * sb;
      3'd2:    p = sa * longint'(ub);
      default: p = ua * ub;
    endcase
    return (f3 == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa = a;
    int sb = b;
    if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : 32'h8000_0000;
      return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return f3[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Divider model: done arrives div_lat cycles after the div_go cycle unless aborted.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      div_done = 1'b0;
      if (pending && !div_never) begin
        cnt--;
        if (cnt == 0) begin
          div_done = 1'b1;
          div_rd   = dres;
          pending  = 1'b0;
        end
      end
      #2;
      if (!clr_n || div_clr) begin
        pending = 1'b0;
      end else if (div_go) begin
        pending = 1'b1;
        cnt     = div_lat;
        dres    = ref_div({1'b1, div_func3}, div_rs1, div_rs2);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int budget);
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = rd;
    r_lat = -1; r_data = '0; r_err = 1'b0; r_rd = '0; r_gos = 0; r_clrs = 0;
    r_go_at = -1; r_clr_at = -1; r_stalls = 0; r_unstable = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_funct3 = 3'($urandom); req_rs1 = $urandom; req_rs2 = $urandom;
      req_rd = 5'($urandom);
      #1;
      if (stall) r_stalls++;
      if (div_go) begin r_gos++; r_go_at = k; end
      if (div_clr) begin r_clrs++; r_clr_at = k; end
      if (r_gos > 0 && {div_func3, div_rs1, div_rs2} !== {f3[1:0], a, b}) r_unstable++;
      if (rsp_valid) begin
        r_lat = k; r_data = rsp_data; r_err = rsp_err; r_rd = rsp_rd;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    #3;
    n_tests++;
    if ({req_ready, stall, rsp_valid, rsp_err, div_go, div_clr} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 100000",
               {req_ready, stall, rsp_valid, rsp_err, div_go, div_clr});
    end
    n_tests++;
    if ({div_rs1, div_rs2, rsp_data, rsp_rd, div_func3} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%h/%h/%h want all 0",
               div_rs1, div_rs2, rsp_data, rsp_rd, div_func3);
    end
    @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  task automatic test_mul();
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 10);
    n_tests++;
    if (r_data !== 32'hFFFF_FFEB) begin
      n_fail++; $display("FAIL mul_data: got %h want ffffffeb", r_data);
    end
    n_tests++;
    if (r_lat !== 2 || r_stalls !== 2) begin
      n_fail++; $display("FAIL mul_timing: got lat %0d stall %0d want 2 2", r_lat, r_stalls);
    end
    n_tests++;
    if (r_rd !== 5'd5 || r_err !== 1'b0 || r_gos !== 0) begin
      n_fail++; $display("FAIL mul_rd: got rd %0d err %b go %0d want 5 0 0", r_rd, r_err, r_gos);
    end
    @(posedge clk);
    #2;
    n_tests++;
    if (req_ready !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL mul_ready_after: got %b%b want 10", req_ready, stall);
    end
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 10);
    n_tests++;
    if (r_data !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL mulhu_data: got %h want fffffffe", r_data);
    end
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 10);
    n_tests++;
    if (r_data !== 32'h0) begin
      n_fail++; $display("FAIL mulh_data: got %h want 00000000", r_data);
    end
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 10);
    n_tests++;
    if (r_data !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL mulhsu_data: got %h want ffffffff", r_data);
    end
  endtask

  task automatic test_div();
    div_never = 1'b0;
    div_lat   = 33;
    do_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd9, 100);
    n_tests++;
    if (r_data !== 32'hFFFF_FFFA || r_err !== 1'b0) begin
      n_fail++; $display("FAIL div_data: got %h err %b want fffffffa 0", r_data, r_err);
    end
    n_tests++;
    if (r_gos !== 1 || r_go_at !== 1 || r_clrs !== 0 || r_unstable !== 0) begin
      n_fail++;
      $display("FAIL div_handshake: got go %0d@%0d clr %0d unstable %0d want 1@1 0 0",
               r_gos, r_go_at, r_clrs, r_unstable);
    end
    n_tests++;
    if (r_lat !== 35 || r_rd !== 5'd9) begin
      n_fail++; $display("FAIL div_latency: got %0d rd %0d want 35 9", r_lat, r_rd);
    end
  endtask

  task automatic test_special();
    div_never = 1'b0;
    div_lat   = 4;
    do_op(3'd5, 32'd5, 32'd0, 5'd10, 20);
    n_tests++;
    if (r_data !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL divu_zero_data: got %h want ffffffff", r_data);
    end
`ifdef DIV_SPECIAL_EN
    n_tests++;
    if (r_lat !== 2 || r_gos !== 0) begin
      n_fail++; $display("FAIL divu_zero_path: got lat %0d go %0d want 2 0", r_lat, r_gos);
    end
`else
    n_tests++;
    if (r_lat !== 6 || r_gos !== 1) begin
      n_fail++; $display("FAIL divu_zero_path: got lat %0d go %0d want 6 1", r_lat, r_gos);
    end
`endif
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 20);
    n_tests++;
    if (r_data !== 32'h0) begin
      n_fail++; $display("FAIL rem_ovf_data: got %h want 00000000", r_data);
    end
`ifdef DIV_SPECIAL_EN
    n_tests++;
    if (r_lat !== 2 || r_gos !== 0) begin
      n_fail++; $display("FAIL rem_ovf_path: got lat %0d go %0d want 2 0", r_lat, r_gos);
    end
`else
    n_tests++;
    if (r_lat !== 6 || r_gos !== 1) begin
      n_fail++; $display("FAIL rem_ovf_path: got lat %0d go %0d want 6 1", r_lat, r_gos);
    end
`endif
  endtask

  task automatic test_timeout();
    div_never = 1'b1;
    do_op(3'd5, 32'd100, 32'd7, 5'd12, 120);
    n_tests++;
    if (r_data !== 32'hFFFF_FFFF || r_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_rsp: got %h err %b want ffffffff 1", r_data, r_err);
    end
    n_tests++;
    if (r_clrs !== 1 || (r_clr_at - r_go_at) !== TO || r_lat !== TO + 2) begin
      n_fail++;
      $display("FAIL timeout_clr: got clr %0d gap %0d lat %0d want 1 %0d %0d",
               r_clrs, r_clr_at - r_go_at, r_lat, TO, TO + 2);
    end
    div_never = 1'b0;
    div_lat   = 5;
    do_op(3'd5, 32'd9, 32'd2, 5'd13, 40);
    n_tests++;
    if (r_data !== 32'd4 || r_err !== 1'b0) begin
      n_fail++; $display("FAIL after_timeout: got %h err %b want 00000004 0", r_data, r_err);
    end
    // done lands on the timeout cycle: done must win
    div_lat = TO;
    do_op(3'd4, 32'd77, 32'd7, 5'd14, 120);
    n_tests++;
    if (r_data !== 32'd11 || r_err !== 1'b0 || r_clrs !== 0) begin
      n_fail++;
      $display("FAIL done_vs_timeout: got %h err %b clr %0d want 0000000b 0 0",
               r_data, r_err, r_clrs);
    end
  endtask

  task automatic test_flush();
    int seen;
    div_never = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = 3'd4; req_rs1 = 32'd50; req_rs2 = 32'd5;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    n_tests++;
    if (div_clr !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_wait_clr: got clr %b rsp %b want 1 0", div_clr, rsp_valid);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_wait_idle: got ready %b stall %b want 1 0", req_ready, stall);
    end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      if (rsp_valid || div_clr) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL flush_wait_quiet: got %0d stray pulses want 0", seen);
    end
    // flush in the DIV_GO cycle: go and abort together
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = 3'd5; req_rs1 = 32'd8; req_rs2 = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b1;
    #1;
    n_tests++;
    if (div_go !== 1'b1 || div_clr !== 1'b1) begin
      n_fail++; $display("FAIL flush_go: got go %b clr %b want 1 1", div_go, div_clr);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_go_idle: got stall %b want 0", stall);
    end
    // flush in WB suppresses the response
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = 3'd0; req_rs1 = 32'd3; req_rs2 = 32'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL flush_wb: got rsp %b stall %b want 0 1", rsp_valid, stall);
    end
    // flush in IDLE blocks the accept
    @(posedge clk); #1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_idle: got stall %b ready %b want 0 1", stall, req_ready);
    end
    div_never = 1'b0;
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = 3'd0; req_rs1 = 32'h1234; req_rs2 = 32'h10; req_rd = 5'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    clr_n = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, stall, rsp_valid, div_go, div_clr} !== 5'b10000 || div_rs1 !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got %b rs1 %h want 10000 00000000",
               {req_ready, stall, rsp_valid, div_go, div_clr}, div_rs1);
    end
    @(posedge clk); #1;
    clr_n = 1'b1;
    do_op(3'd0, 32'd6, 32'd7, 5'd4, 10);
    n_tests++;
    if (r_data !== 32'd42 || r_lat !== 2) begin
      n_fail++; $display("FAIL post_reset_mul: got %h lat %0d want 0000002a 2", r_data, r_lat);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b, exp_data;
    logic [4:0]  rd;
    int          exp_lat, exp_gos;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      b  = $urandom;
      if ($urandom_range(0, 4) == 0) b = 32'hFFFF_FFFF;
      if ($urandom_range(0, 5) == 0) b = 32'h0;
      rd = 5'($urandom);
      div_lat = $urandom_range(1, 40);
      if (!f3[2]) begin
        exp_data = ref_mul(f3, a, b); exp_lat = 2; exp_gos = 0;
      end else begin
        exp_data = ref_div(f3, a, b); exp_lat = div_lat + 2; exp_gos = 1;
`ifdef DIV_SPECIAL_EN
        if (is_special(f3, a, b)) begin exp_lat = 2; exp_gos = 0; end
`endif
      end
      do_op(f3, a, b, rd, 100);
      n_tests++;
      if (r_data !== exp_data || r_rd !== rd || r_err !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_data[%0d] f3=%0d a=%h b=%h: got %h rd %0d err %b want %h rd %0d err 0",
                 i, f3, a, b, r_data, r_rd, r_err, exp_data, rd);
      end
      n_tests++;
      if (r_lat !== exp_lat || r_gos !== exp_gos || r_unstable !== 0) begin
        n_fail++;
        $display("FAIL rand_timing[%0d]: got lat %0d go %0d unstable %0d want %0d %0d 0",
                 i, r_lat, r_gos, r_unstable, exp_lat, exp_gos);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_timeout();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
